// File: rtl/alu_unit_if.sv
// alu_unit_if: operand/opcode inputs and registered result outputs of the execute-stage ALU
interface alu_unit_if #(
    parameter int dataWidth   = 32,
    parameter int selectWidth = 4
);
    logic [dataWidth-1:0]   inputA;
    logic [dataWidth-1:0]   inputB;
    logic [selectWidth-1:0] ALUSelect;
    logic [dataWidth-1:0]   dataOut;
    logic [dataWidth-1:0]   dataOutHigh;

    modport master (
        output inputA, inputB, ALUSelect,
        input  dataOut, dataOutHigh
    );

    modport slave (
        input  inputA, inputB, ALUSelect,
        output dataOut, dataOutHigh
    );
endinterface

// File: rtl/alu_unit.sv
// alu_unit: registered RV32 execute-stage ALU with one-cycle latency
// and a double-width unsigned product for MUL.
module alu_unit #(
    parameter int dataWidth   = 32,
    parameter int selectWidth = 4
) (
    input logic       clk,
    input logic       reset,
    alu_unit_if.slave bus
);
    localparam logic [selectWidth-1:0] OP_ADD = selectWidth'(0);
    localparam logic [selectWidth-1:0] OP_SUB = selectWidth'(1);
    localparam logic [selectWidth-1:0] OP_MUL = selectWidth'(2);
    localparam logic [selectWidth-1:0] OP_AND = selectWidth'(3);
    localparam logic [selectWidth-1:0] OP_OR  = selectWidth'(4);
    localparam logic [selectWidth-1:0] OP_XOR = selectWidth'(5);
    localparam logic [selectWidth-1:0] OP_NOT = selectWidth'(6);
    localparam logic [selectWidth-1:0] OP_SLL = selectWidth'(7);
    localparam logic [selectWidth-1:0] OP_SRL = selectWidth'(8);

    logic [2*dataWidth-1:0] product;
    logic                   shift_out;
    logic [dataWidth-1:0]   result_lo;
    logic [dataWidth-1:0]   result_hi;

    assign product   = (2*dataWidth)'(bus.inputA) * (2*dataWidth)'(bus.inputB);
    // the whole of inputB is the shift amount, so anything past the width clears the result
    assign shift_out = bus.inputB >= dataWidth[dataWidth-1:0];

    always_comb begin
        result_lo = '0;
        result_hi = '0;
        case (bus.ALUSelect)
            OP_ADD: result_lo = bus.inputA + bus.inputB;
            OP_SUB: result_lo = bus.inputA - bus.inputB;
            OP_MUL: {result_hi, result_lo} = product;
            OP_AND: result_lo = bus.inputA & bus.inputB;
            OP_OR:  result_lo = bus.inputA | bus.inputB;
            OP_XOR: result_lo = bus.inputA ^ bus.inputB;
            OP_NOT: result_lo = ~bus.inputA;
            OP_SLL: result_lo = shift_out ? '0 : bus.inputA << bus.inputB;
            OP_SRL: result_lo = shift_out ? '0 : bus.inputA >> bus.inputB;
            default: result_lo = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.dataOut     <= '0;
            bus.dataOutHigh <= '0;
        end else begin
            bus.dataOut     <= result_lo;
            bus.dataOutHigh <= result_hi;
        end
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed vectors pushed to a scoreboard queue; a monitor
// compares each registered result one edge after its inputs were applied.
module tb_alu_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;

    alu_unit_if #(.dataWidth(32), .selectWidth(4)) bus ();

    alu_unit #(.dataWidth(32), .selectWidth(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi, input string nm);
        exp_t e;
        @(negedge clk);
        bus.ALUSelect = op;
        bus.inputA    = a;
        bus.inputB    = b;
        e.lo = lo;
        e.hi = hi;
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic check_now(input string nm);
        total++;
        if (bus.dataOut !== 32'h0 || bus.dataOutHigh !== 32'h0) begin
            bad++;
            $display("FAIL %s: got lo=%h hi=%h expected lo=00000000 hi=00000000",
                     nm, bus.dataOut, bus.dataOutHigh);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (bus.dataOut !== e.lo || bus.dataOutHigh !== e.hi) begin
                    bad++;
                    $display("FAIL %s: got lo=%h hi=%h expected lo=%h hi=%h",
                             e.nm, bus.dataOut, bus.dataOutHigh, e.lo, e.hi);
                end
            end
        end
    end

    initial begin
        int guard;
        bus.ALUSelect = 4'd0;
        bus.inputA    = 32'd0;
        bus.inputB    = 32'd0;
        #3 reset = 1'b1;
        #1 check_now("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_now("reset_hold");
        reset = 1'b0;

        issue(4'd0, 32'd8, 32'd8, 32'h10, 32'h0, "add_8_8");
        issue(4'd0, 32'd8, 32'd7, 32'hF, 32'h0, "add_8_7");
        issue(4'd0, 32'hFFFFFFFF, 32'd2, 32'h1, 32'h0, "add_wrap");
        issue(4'd1, 32'd3, 32'd7, 32'hFFFFFFFC, 32'h0, "sub_3_7");
        issue(4'd1, 32'd7, 32'd7, 32'h0, 32'h0, "sub_7_7");
        issue(4'd2, 32'd3, 32'd7, 32'h15, 32'h0, "mul_3_7");
        issue(4'd2, 32'd7, 32'd7, 32'h31, 32'h0, "mul_7_7");
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, "mul_max");
        issue(4'd0, 32'd1, 32'd1, 32'h2, 32'h0, "add_clears_high");
        issue(4'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 32'h0, "and_zero");
        issue(4'd3, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'h0, "and_pass");
        issue(4'd4, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h0, "or_ones");
        issue(4'd5, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 32'h0, "xor_alt");
        issue(4'd5, 32'hFFFF0000, 32'h00FFFF00, 32'hFF00FF00, 32'h0, "xor_mix");
        issue(4'd6, 32'h12345678, 32'h0, 32'hEDCBA987, 32'h0, "not_val");
        issue(4'd6, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, "not_zero_b_ignored");
        issue(4'd7, 32'd1, 32'd32, 32'h0, 32'h0, "sll_by_32");
        issue(4'd7, 32'd1, 32'd1, 32'h2, 32'h0, "sll_by_1");
        issue(4'd7, 32'd1, 32'h21, 32'h0, 32'h0, "sll_by_33");
        issue(4'd7, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'h0, "sll_by_0");
        issue(4'd8, 32'h80000000, 32'd31, 32'h1, 32'h0, "srl_by_31");
        issue(4'd8, 32'd2, 32'd1, 32'h1, 32'h0, "srl_by_1");
        issue(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, "srl_by_huge");
        issue(4'd8, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'h0, "srl_by_0");
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, "mul_before_op12");
        issue(4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, "op12_zero");
        issue(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, "op9_zero");
        issue(4'd15, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, "op15_zero");

        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, "mul_pre_reset");
        issue(4'd0, 32'd5, 32'd5, 32'h0, 32'h0, "reset_discards");
        #2 reset = 1'b1;
        #1 check_now("reset_midstream_async");
        issue(4'd0, 32'd8, 32'd8, 32'h10, 32'h0, "first_after_reset");
        reset = 1'b0;

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got pending=%0d expected pending=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
